bcd_scan_ctrl: RTL

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

---
 rtl/bcd_scan_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl
//   Converts a 32-bit unsigned value to four BCD digits (value mod 10000) with
//   a 32-step shift-and-add-3 conversion, then drives a 4-digit multiplexed
//   7-segment display.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, leading zero digits (thousands, hundreds, tens) are blanked;
//     the units digit is always shown.
//
// Ports
//   clk    in   1  clock, all state changes on rising edge
//   rst    in   1  asynchronous active-high reset
//   data   in  32  value to convert, sampled when start is accepted
//   start  in   1  conversion request, accepted only while busy=0
//   busy   out  1  high while a conversion is in progress
//   done   out  1  one-cycle pulse when new digits are committed
//   anode  out  4  active-low one-hot digit enable, bit0 = units
//   seg    out  7  active-low segments {g,f,e,d,c,b,a}

module bcd_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  anode,
    output logic [6:0]  seg
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        load, step, commit;

    logic [31:0] shift_q;
    logic [15:0] bcd_q;
    logic [4:0]  iter_q;
    logic [15:0] digits_q;

    logic [15:0] bcd_adj;
    logic [47:0] cat_sh;
    logic [15:0] bcd_nxt;
    logic [31:0] shift_nxt;

    logic [CW-1:0] refresh_q;
    logic [1:0]    index_q;

    logic [3:0]  slot_digit;
    logic        blank;
    logic [6:0]  dec;
    logic [3:0]  anode_nxt;
    logic [6:0]  seg_nxt;

    // ---------------------------------------------------------------
    // Conversion FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (iter_q == 5'd31) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CONV);

    // ---------------------------------------------------------------
    // Shift-and-add-3 datapath. Only four BCD nibbles are kept; carries
    // never flow downward, so the low four digits are exact and the bit
    // leaving the thousands nibble is simply dropped.
    // ---------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        cat_sh    = {bcd_adj, shift_q} << 1;
        bcd_nxt   = cat_sh[47:32];
        shift_nxt = cat_sh[31:0];
    end

    // The committed digits take the result of the final step directly, so
    // they change only on the last conversion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            digits_q <= '0;
            done     <= 1'b0;
        end else begin
            done <= commit;
            if (load) begin
                shift_q <= data;
                bcd_q   <= '0;
                iter_q  <= '0;
            end else if (step) begin
                shift_q <= shift_nxt;
                bcd_q   <= bcd_nxt;
                iter_q  <= iter_q + 5'd1;
            end
            if (commit) begin
                digits_q <= bcd_nxt;
            end
        end
    end

    // ---------------------------------------------------------------
    // Display scanning, free-running regardless of conversion state
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            index_q   <= '0;
        end else begin
            if (refresh_q == CW'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                index_q   <= index_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
        end
    end

    always_comb begin
        slot_digit = digits_q[{index_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((index_q == 2'd3) && (digits_q[15:12] == 4'd0)) ||
                ((index_q == 2'd2) && (digits_q[15:8]  == 8'd0)) ||
                ((index_q == 2'd1) && (digits_q[15:4]  == 12'd0));
`else
        blank = 1'b0;
`endif
        case (slot_digit)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
        anode_nxt = ~(4'b0001 << index_q);
        seg_nxt   = blank ? 7'b1111111 : dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode <= '1;
            seg   <= '1;
        end else begin
            anode <= anode_nxt;
            seg   <= seg_nxt;
        end
    end

endmodule
